// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package hilo_muldiv_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Signed variants operate on magnitudes and need a sign fix-up at the end.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface hilo_muldiv_unit_if
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic              i_start;
    logic [2:0]        i_op;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_hi;
    logic [DATA_W-1:0] o_lo;

    // Requester side (decode/EX stage or testbench).
    modport master (
        output i_start, i_op, i_rs_data, i_rt_data,
        input  o_busy, o_done, o_hi, o_lo
    );

    // Unit side.
    modport slave (
        input  i_start, i_op, i_rs_data, i_rt_data,
        output o_busy, o_done, o_hi, o_lo
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-step datapath: shift-add multiply or restoring shift-subtract divide on magnitudes.
// Multiply: acc = {partial_hi, multiplier}, product ends up in acc.
// Divide:   acc = {remainder, dividend->quotient}, remainder/quotient end up in acc halves.
module muldiv_iter_core
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_is_div,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_opa,   // multiplicand or dividend magnitude
    input  logic [DATA_W-1:0] i_opb,   // multiplier or divisor magnitude
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opnd;
    logic                r_is_div;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_rem_sh;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_acc_next;

    // Next accumulator value for one multiply or divide step.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
        w_rem_sh   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opnd});
        // Only used when w_ge, so the true difference always fits in DATA_W bits.
        w_diff     = w_rem_sh[DATA_W-1:0] - r_opnd;
        w_acc_next = r_acc;
        if (r_is_div) begin
            if (w_ge) begin
                w_acc_next = {w_diff, r_acc[DATA_W-2:0], 1'b1};
            end else begin
                w_acc_next = {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_acc_next = {w_sum, r_acc[DATA_W-1:1]};
        end
    end

    // Operand load on accept, one iteration per step enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_acc    <= {{DATA_W{1'b0}}, (i_is_div ? i_opa : i_opb)};
            r_opnd   <= i_is_div ? i_opb : i_opa;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
        end
    end

    assign o_hi = r_acc[2*DATA_W-1:DATA_W];
    assign o_lo = r_acc[DATA_W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO: FSM, iteration counter, sign handling, HI/LO regs.
module hilo_muldiv_unit
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    hilo_muldiv_unit_if.slave  io_bus
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_sign_rs;
    logic                r_sign_rt;
    logic                r_rt_zero;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                w_accept;
    logic                w_load;
    logic                w_signed;
    logic                w_is_div_in;
    logic                w_rs_neg;
    logic                w_rt_neg;
    logic [DATA_W-1:0]   w_rs_mag;
    logic [DATA_W-1:0]   w_rt_mag;
    logic [DATA_W-1:0]   w_core_hi;
    logic [DATA_W-1:0]   w_core_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_fix_hi;
    logic [DATA_W-1:0]   w_fix_lo;

    // Request decode and operand magnitudes for signed ops.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && io_bus.i_start;
        w_load      = w_accept && (io_bus.i_op <= OP_DIV);
        w_signed    = is_signed_op(io_bus.i_op);
        w_is_div_in = is_div_op(io_bus.i_op);
        w_rs_neg    = w_signed && io_bus.i_rs_data[DATA_W-1];
        w_rt_neg    = w_signed && io_bus.i_rt_data[DATA_W-1];
        w_rs_mag    = w_rs_neg ? -io_bus.i_rs_data : io_bus.i_rs_data;
        w_rt_mag    = w_rt_neg ? -io_bus.i_rt_data : io_bus.i_rt_data;
    end

    muldiv_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_is_div (w_is_div_in),
        .i_step   (r_state == ST_RUN),
        .i_opa    (w_rs_mag),
        .i_opb    (w_rt_mag),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    // Sign correction of the magnitude result. Divide-by-zero keeps the all-ones quotient, and
    // re-signing the remainder then restores the original rs value.
    always_comb begin
        w_prod   = {w_core_hi, w_core_lo};
        w_fix_hi = w_core_hi;
        w_fix_lo = w_core_lo;
        if (r_is_div) begin
            if ((r_sign_rs ^ r_sign_rt) && !r_rt_zero) begin
                w_fix_lo = -w_core_lo;
            end
            if (r_sign_rs) begin
                w_fix_hi = -w_core_hi;
            end
        end else if (r_sign_rs ^ r_sign_rt) begin
            {w_fix_hi, w_fix_lo} = -w_prod;
        end
    end

    // Control FSM with registered busy/done and the architectural HI/LO registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_sign_rs <= 1'b0;
            r_sign_rt <= 1'b0;
            r_rt_zero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (io_bus.i_op)
                            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                                r_is_div  <= w_is_div_in;
                                r_sign_rs <= w_rs_neg;
                                r_sign_rt <= w_rt_neg;
                                r_rt_zero <= (io_bus.i_rt_data == '0);
                                r_cnt     <= '0;
                                r_busy    <= 1'b1;
                                r_state   <= ST_RUN;
                            end
                            OP_MTHI: r_hi <= io_bus.i_rs_data;
                            OP_MTLO: r_lo <= io_bus.i_rs_data;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.o_busy = r_busy;
    assign io_bus.o_done = r_done;
    assign io_bus.o_hi   = r_hi;
    assign io_bus.o_lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO, monitor pops on done.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.DATA_W(W)) bus ();

    hilo_muldiv_unit #(.DATA_W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        logic [63:0] e;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: got o_done=1, expected 0 (hi=0x%08h lo=0x%08h)",
                             bus.o_hi, bus.o_lo);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, "_hi"}, bus.o_hi, e[63:32]);
                    check({nm, "_lo"}, bus.o_lo, e[31:0]);
                end
            end
        end
    end

    // Issue a multi-cycle op; check latency, busy length and HI/LO stability while busy.
    // inject_at >= 0 pulses an MTLO 0x55 request at that busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el, input string name,
                          input int inject_at);
        int          lat;
        int          busy_cnt;
        logic        held;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = bus.o_hi;
        l0 = bus.o_lo;
        exp_q.push_back({eh, el});
        name_q.push_back(name);
        bus.i_op      = op;
        bus.i_rs_data = rs;
        bus.i_rt_data = rt;
        bus.i_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        held     = 1'b1;
        while (bus.o_done !== 1'b1 && lat < 60) begin
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (bus.o_hi !== h0 || bus.o_lo !== l0) held = 1'b0;
            if (lat == inject_at) begin
                bus.i_op      = OP_MTLO;
                bus.i_rs_data = 32'h55;
                bus.i_start   = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.i_start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd33);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({name, "_hilo_held"}, {31'd0, held}, 32'd1);
    endtask

    // Single-cycle op (MTHI/MTLO/no-op): result visible next cycle, no busy, no done.
    task automatic mt_op(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] eh, input logic [31:0] el, input string name);
        bus.i_op      = op;
        bus.i_rs_data = rs;
        bus.i_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check({name, "_hi"}, bus.o_hi, eh);
        check({name, "_lo"}, bus.o_lo, el);
        check({name, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
        check({name, "_done"}, {31'd0, bus.o_done}, 32'd0);
    endtask

    initial begin
        bus.i_start   = 1'b0;
        bus.i_op      = '0;
        bus.i_rs_data = '0;
        bus.i_rt_data = '0;

        #12;
        check("reset_busy", {31'd0, bus.o_busy}, 32'd0);
        check("reset_done", {31'd0, bus.o_done}, 32'd0);
        check("reset_hi", bus.o_hi, 32'd0);
        check("reset_lo", bus.o_lo, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", -1);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", -1);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7", -1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2", -1);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2", -1);
        run_op(OP_DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, "divu_by0", -1);
        run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, "div_by0", -1);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf", -1);

        mt_op(OP_MTHI, 32'hCAFE, 32'hCAFE, 32'h8000_0000, "mthi");
        mt_op(OP_MTLO, 32'h1111, 32'hCAFE, 32'h1111, "mtlo");
        mt_op(3'd6, 32'hDEAD, 32'hCAFE, 32'h1111, "nop6");
        mt_op(3'd7, 32'hBEEF, 32'hCAFE, 32'h1111, "nop7");

        // MTLO during busy is dropped; next op starts in the done cycle.
        run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_inject", 5);
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6,  "multu_b2b", -1);

        // Asynchronous reset in the middle of a divide.
        bus.i_op      = OP_DIVU;
        bus.i_rs_data = 32'd1000;
        bus.i_rt_data = 32'd3;
        bus.i_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midop_busy", {31'd0, bus.o_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_done", {31'd0, bus.o_done}, 32'd0);
        check("rst_hi", bus.o_hi, 32'd0);
        check("rst_lo", bus.o_lo, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "multu_after_rst", -1);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit for the EX stage.
- Consumes the rs/rt operand values produced by the register-file read port and owns the architectural HI and LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
- MFHI/MFLO are served by reading o_hi/o_lo directly.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  operation request, sampled on rising edge
- i_op  in  3  operation code (see Behaviour)
- i_rs_data  in  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO source)
- i_rt_data  in  DATA_W  rt operand (divisor / multiplier)
- o_busy  out  1  multi-cycle operation in progress
- o_done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- o_hi  out  DATA_W  HI register
- o_lo  out  DATA_W  LO register

Behaviour:
- Clock and reset: single clock domain, i_clk. Reset is asynchronous, active-low on i_rst_n.
- Reset: i_rst_n low clears HI=0, LO=0, o_busy=0, o_done=0, state=IDLE, iteration counter=0. Effect is immediate and asynchronous, including mid-operation; the partial result is discarded.
- i_op encoding:
  - 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO
  - 6 and 7 are no-ops: accepted and ignored, no state change.
- States: IDLE, RUN, FIX.
- IDLE:
  - i_start=1 with op 0-3 latches operands and op (edge E0), then goes to RUN with counter=0.
  - Signed ops latch operand magnitudes plus the two sign bits.
  - i_start=1 with MTHI/MTLO writes HI/LO from i_rs_data at E0; next cycle o_hi/o_lo show the new value. No busy, no done.
- RUN:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per edge.
  - Counter increments; after DATA_W steps (edges E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction and write HI/LO.
  - Return to IDLE with o_done=1 for exactly the cycle after E33.
- o_busy is high in the cycles after E0 through E32 (33 cycles). o_done is low otherwise.
- Total latency: start edge to results visible = 33 edges; o_done and new o_hi/o_lo appear together.
- i_start while o_busy=1: ignored entirely (no re-latch, no MTHI/MTLO write). The stall is the decode stage's job.
- i_start in the o_done cycle: accepted normally (the unit is in IDLE).
- Multiply result: 2*DATA_W product, HI=upper half, LO=lower half.
  - MULT negates the product iff the operand signs differ.
- Divide result: LO=quotient, HI=remainder.
  - DIV negates the quotient iff signs differ; the remainder takes the dividend's sign.
- Divide by zero (rt=0), both DIVU and DIV: LO=all-ones, HI=i_rs_data unchanged, no sign correction. Still takes the full 33 edges and pulses o_done.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- o_hi/o_lo hold their values between writes. They never show intermediate iteration state.

Decomposition:
- Shared package hilo_muldiv_pkg:
  - op-code localparams: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO
  - state encodings: ST_IDLE, ST_RUN, ST_FIX
  - DATA_W default
- One sub-module: muldiv_iter_core. It holds the 2*DATA_W accumulator/remainder plus quotient shift register and performs one add-or-subtract step per enable.
- The top level keeps the FSM, counter, sign handling, and HI/LO registers.

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> o_busy 33 cycles, then o_done pulse with HI=0xFFFFFFFE LO=0x00000001.
2. MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB. DIVU rs=100 rt=7 -> LO=14 HI=2.
3. DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF. DIV rs=7 rt=0xFFFFFFFE -> LO=0xFFFFFFFD HI=1.
4. Boundaries:
   - DIVU rs=0x1234 rt=0 -> LO=0xFFFFFFFF HI=0x1234, done after 33 edges.
   - DIV rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000 HI=0.
5. Sequencing:
   - MTHI rs=0xCAFE -> o_hi=0xCAFE next cycle, o_done stays 0.
   - Start MULTU 3*4, pulse i_start with MTLO 0x55 at busy cycle 5 -> ignored; final HI=0 LO=12.
   - Back-to-back start in the o_done cycle is accepted.
6. Reset mid-op: start DIVU, drop i_rst_n at busy cycle 10 -> o_busy=0, o_done=0, HI=LO=0 immediately. After release, MULTU 5*6 -> LO=30 after 33 edges.
